// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial adder with a valid/ready handshake on both sides. Operands are
//   latched in IDLE, added one bit per cycle (LSB first) in RUN, and the result
//   is held in DONE until the consumer takes it.
//
//   Optional feature macro: SERIAL_ADDER_OVF_EN adds the registered signed
//   overflow output 'ovf'.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands a/b valid
//   in_ready   block can accept operands (IDLE only)
//   a, b       WIDTH-bit operands
//   out_valid  sum/carry_out valid (DONE only)
//   out_ready  consumer accepts the result
//   sum        registered result, a+b mod 2^WIDTH
//   carry_out  carry out of the MSB
//   busy       high while in RUN
//   ovf        (SERIAL_ADDER_OVF_EN) carry into MSB ^ carry out of MSB
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state;
    logic [WIDTH-1:0] a_r, b_r;
    logic            c;
    logic [IW-1:0]   idx;

    // full adder as two half-adder stages
    logic ai, bi, hs, hc, s, cn, last;
    assign ai   = a_r[idx];
    assign bi   = b_r[idx];
    assign hs   = ai ^ bi;
    assign hc   = ai & bi;
    assign s    = hs ^ c;
    assign cn   = hc | (c & hs);
    assign last = (idx == IW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            a_r       <= '0;
            b_r       <= '0;
            c         <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b;
                        c        <= 1'b0;
                        idx      <= '0;
                        state    <= S_RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    sum[idx] <= s;
                    c        <= cn;
                    if (last) begin
                        // idx stays at WIDTH-1; it is re-zeroed on the next accept
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        carry_out <= cn;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf       <= c ^ cn;  // c is the carry into the MSB here
`endif
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                S_DONE: begin
                    // completion edge returns to IDLE; accepting waits a cycle
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, in_valid, out_ready;
    logic [W-1:0] a, b;
    logic         in_ready, out_valid, carry_out, busy;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 computing, 2 result presented
    int           m_phase = 0;
    int           m_cnt = 0;
    logic [W-1:0] m_sum = '0, m_sum_p = '0;
    logic         m_co = 0, m_co_p = 0, m_ovf = 0, m_ovf_p = 0;

    always @(posedge clk) begin
        logic [W:0] t;
        if (rst) begin
            m_phase = 0; m_sum = '0; m_co = 0; m_ovf = 0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    t        = {1'b0, a} + {1'b0, b};
                    m_sum_p  = t[W-1:0];
                    m_co_p   = t[W];
                    m_ovf_p  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
                    m_cnt    = W;
                    m_phase  = 1;
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_phase = 2; m_sum = m_sum_p; m_co = m_co_p; m_ovf = m_ovf_p;
                    end
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    // per-cycle compare, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, m_phase == 0);
            chk("busy", busy, m_phase == 1);
            chk("out_valid", out_valid, m_phase == 2);
            if (m_phase != 1) begin
                chk("sum", sum, m_sum);
                chk("carry_out", carry_out, m_co);
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf", ovf, m_ovf);
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic op(input logic [W-1:0] aa, input logic [W-1:0] bb, input int hold,
                      input bit junk, output logic [W-1:0] rs, output logic rc, output int lat);
        int n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        in_valid = 1; a = aa; b = bb;
        step();
        if (junk) begin a = 8'h01; b = 8'h01; end
        else in_valid = 0;
        n = 0;
        while (!out_valid && n < 40) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        out_ready = 0;
        lat = n;
        if (!out_valid) chk("out_valid_timeout", 0, 1);
        rs = sum; rc = carry_out;
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_sum", sum, rs);
            chk("hold_valid", out_valid, 1);
        end
        out_ready = 1;
        step();
        out_ready = 0; in_valid = 0;
        chk("back_idle", in_ready, 1);
    endtask

    initial begin
        logic [W-1:0] rs;
        logic         rc;
        int           lat;

        rst = 1; in_valid = 0; out_ready = 0; a = '0; b = '0;
        step();
        chk_en = 1;
        chk("rst_sum", sum, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        step();
        rst = 0;

        // basic add and latency
        op(8'h0F, 8'h01, 0, 0, rs, rc, lat);
        chk("lit_basic_sum", rs, 8'h10);
        chk("lit_basic_co", rc, 0);
        chk("lit_latency", lat, W);
        chk("model_basic_sum", m_sum, 8'h10);

        // wrap
        op(8'hFF, 8'h01, 1, 0, rs, rc, lat);
        chk("lit_wrap_sum", rs, 8'h00);
        chk("lit_wrap_co", rc, 1);
`ifdef SERIAL_ADDER_OVF_EN
        chk("lit_wrap_ovf", ovf, 0);
`endif
        // signed overflow
        op(8'h7F, 8'h01, 1, 0, rs, rc, lat);
        chk("lit_ovf_sum", rs, 8'h80);
        chk("lit_ovf_co", rc, 0);
        chk("model_ovf", m_ovf, 1);
`ifdef SERIAL_ADDER_OVF_EN
        chk("lit_ovf_ovf", ovf, 1);
`endif
        // backpressure
        op(8'hA5, 8'h5A, 5, 0, rs, rc, lat);
        chk("lit_bp_sum", rs, 8'hFF);
        chk("lit_bp_co", rc, 0);

        // ignored input during RUN/DONE
        op(8'h10, 8'h20, 2, 1, rs, rc, lat);
        chk("lit_ign_sum", rs, 8'h30);

        // reset mid-operation, with in_valid asserted during reset
        in_valid = 1; a = 8'hA5; b = 8'h3C;
        step();
        in_valid = 0;
        repeat (3) step();
        rst = 1; in_valid = 1; a = 8'h01; b = 8'h01;
        step();
        rst = 0; in_valid = 0;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("mid_rst_no_pulse", out_valid, 0);
        end
        op(8'h03, 8'h04, 0, 0, rs, rc, lat);
        chk("lit_post_rst_sum", rs, 8'h07);

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            logic [W-1:0] ra, rb;
            logic [W:0]   t;
            ra = W'($urandom);
            rb = W'($urandom);
            op(ra, rb, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), rs, rc, lat);
            t = {1'b0, ra} + {1'b0, rb};
            chk("rand_sum", rs, t[W-1:0]);
            chk("rand_co", rc, t[W]);
            chk("rand_lat", lat, W);
            repeat ($urandom_range(0, 2)) step();
        end

        step();
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
